// File: rtl/imem_program_loader.sv
// Program loader for the single-cycle core's instruction memory.
// Takes decoded instruction fields over a valid/ready stream, packs each beat
// into a 32-bit RV32I word and writes the words to consecutive addresses from 0.
// The core is held in reset until the final beat of the program has been written.
module imem_program_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        in_fmt,
   input  logic [6:0]        in_op,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7_5,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              overflow_err
);

   localparam logic [1:0] LOAD = 2'd0;
   localparam logic [1:0] DONE = 2'd1;
   localparam logic [1:0] ERR  = 2'd2;

   localparam logic [1:0] FMT_I = 2'b00;
   localparam logic [1:0] FMT_S = 2'b01;
   localparam logic [1:0] FMT_B = 2'b10;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] count;
   logic              full;
   logic              accept;
   logic [31:0]       enc_word;
   logic              unused_imm_bit;

   // imm[0] is never encoded: B offsets are always even and I/S use only [11:0]
   assign unused_imm_bit = in_imm[0];

   // Beats are only taken while loading and while there is still a free slot
   assign in_ready = (state == LOAD) && !full;
   assign accept   = in_valid && in_ready;

   // Pack the decoded fields into an RV32I word according to the format code
   always_comb begin
      enc_word = '0;
      case (in_fmt)
         FMT_I:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
         FMT_S:   enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:0], in_op};
         FMT_B:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_op};
         default: enc_word = {1'b0, in_funct7_5, 5'b0, in_rs2, in_rs1, in_funct3,
                              in_rd, in_op};
      endcase
   end

   // Load sequencing: register the write, advance the address, track full/done/error
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= LOAD;
         count        <= '0;
         full         <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_reset    <= 1'b1;
         done         <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         imem_we <= accept;
         if (accept) begin
            imem_addr  <= count;
            imem_wdata <= enc_word;
            count      <= count + ADDR_ONE;
            if (count == '1) begin
               full <= 1'b1;
            end
            if (in_last) begin
               state     <= DONE;
               done      <= 1'b1;
               cpu_reset <= 1'b0;
            end
         end else if ((state == LOAD) && full && in_valid) begin
            state        <= ERR;
            overflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader.
// Two instances share one stimulus stream: the default 64-word memory and a
// 4-word memory so the capacity boundary is reachable. A behavioural model per
// instance predicts every registered output each cycle; directed vectors add
// hand-computed literal expectations.
module tb_imem_program_loader;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_last;
   logic [1:0]  in_fmt;
   logic [6:0]  in_op;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [12:0] in_imm;

   logic        ready0, we0, cpurst0, done0, ovf0;
   logic [5:0]  addr0;
   logic [31:0] wdata0;
   logic        ready1, we1, cpurst1, done1, ovf1;
   logic [1:0]  addr1;
   logic [31:0] wdata1;

   int checks = 0;
   int errors = 0;

   imem_program_loader dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready0),
      .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3),
      .in_funct7_5(in_funct7_5), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
      .cpu_reset(cpurst0), .done(done0), .overflow_err(ovf0)
   );

   imem_program_loader #(.ADDR_W(2)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready1),
      .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3),
      .in_funct7_5(in_funct7_5), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
      .cpu_reset(cpurst1), .done(done1), .overflow_err(ovf1)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Reference RV32I encoder built from shifts and masks
   function automatic logic [31:0] encode(input int unsigned fmt, op, f3, f75,
                                          rd, rs1, rs2, imm);
      int unsigned w;
      case (fmt)
         0: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         1: w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) |
                (f3 << 12) | ((imm & 31) << 7) | op;
         2: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
                (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
         default: w = (f75 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                      (rd << 7) | op;
      endcase
      return w;
   endfunction

   // Model state per instance: phase 0 loading, 1 done, 2 error
   int          capacity[2] = '{64, 4};
   int          m_phase[2];
   int          m_written[2];
   bit          e_we[2];
   int          e_addr[2];
   logic [31:0] e_wdata[2];
   bit          e_cpurst[2];
   bit          e_done[2];
   bit          e_ovf[2];
   bit          e_rst[2];
   bit          m_live = 1'b0;
   int          wcount = 0;

   // Advance the model on each rising edge from the inputs held since the last falling edge
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         e_rst[i] = reset;
         if (reset) begin
            m_phase[i] = 0; m_written[i] = 0; e_we[i] = 0; e_addr[i] = 0;
            e_wdata[i] = 0; e_cpurst[i] = 1; e_done[i] = 0; e_ovf[i] = 0;
         end else begin
            e_we[i] = 0;
            if (in_valid && m_phase[i] == 0 && m_written[i] < capacity[i]) begin
               e_we[i]    = 1;
               e_addr[i]  = m_written[i];
               e_wdata[i] = encode(in_fmt, in_op, in_funct3, in_funct7_5,
                                   in_rd, in_rs1, in_rs2, in_imm);
               m_written[i]++;
               if (in_last) begin
                  m_phase[i] = 1; e_done[i] = 1; e_cpurst[i] = 0;
               end
            end else if (in_valid && m_phase[i] == 0) begin
               m_phase[i] = 2; e_ovf[i] = 1;
            end
         end
      end
      if (reset) m_live = 1'b1;
   end

   // Compare both instances against the model shortly after each rising edge
   always @(posedge clk) begin
      #1;
      if (m_live) begin
         checkOutput("we0", {31'b0, we0}, {31'b0, e_we[0]});
         checkOutput("we1", {31'b0, we1}, {31'b0, e_we[1]});
         checkOutput("ready0", {31'b0, ready0},
                     {31'b0, (m_phase[0] == 0 && m_written[0] < capacity[0])});
         checkOutput("ready1", {31'b0, ready1},
                     {31'b0, (m_phase[1] == 0 && m_written[1] < capacity[1])});
         checkOutput("cpu_reset0", {31'b0, cpurst0}, {31'b0, e_cpurst[0]});
         checkOutput("cpu_reset1", {31'b0, cpurst1}, {31'b0, e_cpurst[1]});
         checkOutput("done0", {31'b0, done0}, {31'b0, e_done[0]});
         checkOutput("done1", {31'b0, done1}, {31'b0, e_done[1]});
         checkOutput("overflow0", {31'b0, ovf0}, {31'b0, e_ovf[0]});
         checkOutput("overflow1", {31'b0, ovf1}, {31'b0, e_ovf[1]});
         if (e_we[0] || e_rst[0]) begin
            checkOutput("addr0", {26'b0, addr0}, e_addr[0]);
            checkOutput("wdata0", wdata0, e_wdata[0]);
         end
         if (e_we[1] || e_rst[1]) begin
            checkOutput("addr1", {30'b0, addr1}, e_addr[1]);
            checkOutput("wdata1", wdata1, e_wdata[1]);
         end
         if (we0 === 1'b1) wcount++;
      end
   end

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic f75,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [12:0] imm,
                                input logic last);
      @(negedge clk);
      in_valid = 1'b1; in_fmt = fmt; in_op = op; in_funct3 = f3;
      in_funct7_5 = f75; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_last = last;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   int nvalid;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_fmt = 2'b00;
      in_op = 7'h0; in_funct3 = 3'h0; in_funct7_5 = 1'b0; in_rd = 5'h0;
      in_rs1 = 5'h0; in_rs2 = 5'h0; in_imm = 13'h0;

      // Pin the reference encoder to hand-assembled words
      checkOutput("enc_add", encode(3, 7'h33, 0, 0, 3, 1, 2, 0), 32'h002081B3);
      checkOutput("enc_lw", encode(0, 7'h03, 2, 0, 5, 1, 0, 13'h1FFC), 32'hFFC0A283);
      checkOutput("enc_sw", encode(1, 7'h23, 2, 0, 0, 2, 6, 8), 32'h00612423);
      checkOutput("enc_beq", encode(2, 7'h63, 0, 0, 0, 1, 2, 13'h1FF8), 32'hFE208CE3);

      @(negedge clk);
      doReset();
      checkOutput("rst_ready", {31'b0, ready0}, 32'd1);
      checkOutput("rst_cpu_reset", {31'b0, cpurst0}, 32'd1);
      checkOutput("rst_we", {31'b0, we0}, 32'd0);
      checkOutput("rst_done", {31'b0, done0}, 32'd0);

      // add x3,x1,x2 on its own
      applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'h0, 1'b0);
      idle();
      checkOutput("add_we", {31'b0, we0}, 32'd1);
      checkOutput("add_addr", {26'b0, addr0}, 32'd0);
      checkOutput("add_wdata", wdata0, 32'h002081B3);
      checkOutput("add_cpu_reset", {31'b0, cpurst0}, 32'd1);

      // sub then lw back to back
      doReset();
      applyStimulus(2'b11, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'h0, 1'b0);
      applyStimulus(2'b00, 7'h03, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 13'h1FFC, 1'b0);
      checkOutput("sub_addr", {26'b0, addr0}, 32'd0);
      checkOutput("sub_wdata", wdata0, 32'h402081B3);
      idle();
      checkOutput("lw_we", {31'b0, we0}, 32'd1);
      checkOutput("lw_addr", {26'b0, addr0}, 32'd1);
      checkOutput("lw_wdata", wdata0, 32'hFFC0A283);

      // sw then beq as the last instruction
      doReset();
      applyStimulus(2'b01, 7'h23, 3'd2, 1'b0, 5'd0, 5'd2, 5'd6, 13'd8, 1'b0);
      applyStimulus(2'b10, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1);
      checkOutput("sw_wdata", wdata0, 32'h00612423);
      checkOutput("sw_done", {31'b0, done0}, 32'd0);
      idle();
      checkOutput("beq_wdata", wdata0, 32'hFE208CE3);
      checkOutput("beq_addr", {26'b0, addr0}, 32'd1);
      checkOutput("beq_done", {31'b0, done0}, 32'd1);
      checkOutput("beq_cpu_reset", {31'b0, cpurst0}, 32'd0);
      checkOutput("beq_ready", {31'b0, ready0}, 32'd0);
      applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'h0, 1'b0);
      idle();
      checkOutput("after_done_we", {31'b0, we0}, 32'd0);
      checkOutput("after_done_done", {31'b0, done0}, 32'd1);

      // Five beats into a four-word memory
      doReset();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'(k), 5'd1, 5'd2, 13'h0, 1'b0);
         if (k == 4) checkOutput("ovf_last_addr", {30'b0, addr1}, 32'd3);
      end
      idle();
      checkOutput("ovf_flag", {31'b0, ovf1}, 32'd1);
      checkOutput("ovf_we", {31'b0, we1}, 32'd0);
      checkOutput("ovf_cpu_reset", {31'b0, cpurst1}, 32'd1);
      checkOutput("ovf_ready", {31'b0, ready1}, 32'd0);
      checkOutput("big_no_ovf", {31'b0, ovf0}, 32'd0);

      // Last instruction lands in the final slot
      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'(k), 5'd1, 5'd2, 13'h0, 1'(k == 3));
      end
      idle();
      checkOutput("full_done", {31'b0, done1}, 32'd1);
      checkOutput("full_ovf", {31'b0, ovf1}, 32'd0);
      checkOutput("full_addr", {30'b0, addr1}, 32'd3);
      applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 13'h0, 1'b0);
      idle();
      checkOutput("full_extra_ovf", {31'b0, ovf1}, 32'd0);
      checkOutput("full_extra_we", {31'b0, we1}, 32'd0);

      // Reset in the middle of a load, then a one-instruction reload
      doReset();
      applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 13'h0, 1'b0);
      applyStimulus(2'b11, 7'h33, 3'd0, 1'b0, 5'd2, 5'd1, 5'd2, 13'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_we", {31'b0, we0}, 32'd0);
      checkOutput("midrst_addr", {26'b0, addr0}, 32'd0);
      checkOutput("midrst_ready", {31'b0, ready0}, 32'd1);
      reset = 1'b0; in_valid = 1'b0;
      applyStimulus(2'b00, 7'h13, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 13'd5, 1'b1);
      idle();
      checkOutput("reload_addr", {26'b0, addr0}, 32'd0);
      checkOutput("reload_we", {31'b0, we0}, 32'd1);
      checkOutput("reload_done", {31'b0, done0}, 32'd1);

      // Randomly gapped valid with held fields
      doReset();
      wcount = 0;
      nvalid = 0;
      in_fmt = 2'b00; in_op = 7'h13; in_funct3 = 3'd0; in_rd = 5'd4;
      in_rs1 = 5'd3; in_imm = 13'd42; in_last = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         if (in_valid) nvalid++;
      end
      idle();
      idle();
      checkOutput("rand_write_count", wcount, nvalid);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Encoder counterpart to the single-cycle core's instruction decode path.
- Accepts decoded instruction fields (format, opcode, funct3, funct7[5], register numbers, immediate) over a valid/ready stream.
- Packs the fields into 32-bit RV32I words (R/I/S/B) and writes them sequentially into instruction memory starting at word 0.
- Holds the core in reset until the program has been loaded.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity is 2^ADDR_W words

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  field beat valid
in_ready  output  1  loader can accept a beat
in_last  input  1  beat is the final instruction of the program
in_fmt  input  2  format, same code as ImmSrc: 00 I, 01 S, 10 B, 11 R
in_op  input  7  opcode [6:0]
in_funct3  input  3  funct3
in_funct7_5  input  1  funct7 bit 5, used for R format only
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  13  immediate, two's complement; I/S use [11:0], B uses [12:1]
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  encoded instruction
cpu_reset  output  1  reset to the core, high until load completes
done  output  1  program loaded
overflow_err  output  1  beat offered beyond capacity

Behaviour:
- Clocking and reset: single clock domain. Synchronous active-high reset.
- Values during reset: state=LOAD, address counter=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, overflow_err=0, in_ready=1 on the first cycle after reset.
- States: LOAD, DONE, ERR.
- Handshake: a beat transfers on a rising edge where in_valid & in_ready. in_ready = (state==LOAD) & ~full.
- full: set after the write to address 2^ADDR_W-1, i.e. the counter wrapped and a full flag is recorded.
- Latency: a beat accepted at edge N gives imem_we=1 for exactly one cycle after edge N. During that cycle imem_addr = counter value at acceptance and imem_wdata = encoded word. Both outputs are registered.
- Counter: increments by 1 per accepted beat. It never wraps silently.
- Back-to-back beats: one beat per cycle sustained, so imem_we may stay high on consecutive cycles.
- Encoding:
  - R: {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - Fields not used by a format are ignored, including imm[0] for B and imm[12] for I/S.
- LOAD -> DONE: on acceptance of a beat with in_last=1. That beat is still written.
  - done=1 and cpu_reset=0 are registered together in the same cycle as that final imem_we.
  - in_ready=0 in DONE. DONE holds until reset.
- LOAD -> ERR: when full=1 and in_valid=1.
  - No write occurs. overflow_err=1, cpu_reset stays 1, in_ready=0.
  - ERR holds until reset.
- Last slot: in_last on the beat written to address 2^ADDR_W-1 gives DONE, not ERR.
- Reset mid-load: all state returns to reset values. Words already written stay in memory but are overwritten by the next load from address 0. Any in-flight imem_we is cancelled in the reset cycle.
- in_valid while in DONE or ERR: ignored, no writes.

Test Plan:
- R add x3,x1,x2 (fmt 11, op 0110011, f3 000, f7_5 0), in_last=0 -> next cycle imem_we=1, addr 0, wdata 0x002081B3; cpu_reset still 1.
- R sub x3,x1,x2 (f7_5 1), then I lw x5,-4(x1) (fmt 00, op 0000011, f3 010, imm 0x1FFC), back-to-back -> writes 0x402081B3 at addr 0 and 0xFFC0A283 at addr 1 on consecutive cycles.
- S sw x6,8(x2) (fmt 01, op 0100011, f3 010, imm 8) then B beq x1,x2,-8 (fmt 10, op 1100011, f3 000, imm 0x1FF8) with in_last=1 -> writes 0x00612423 and 0xFE208CE3; done=1 and cpu_reset=0 in the final write cycle; in_ready=0 afterwards; further beats produce no writes.
- ADDR_W=2, offer 5 beats, none with in_last -> addrs 0..3 written, 5th beat not written, overflow_err=1, cpu_reset=1. Repeat with in_last on the 4th beat -> done=1, overflow_err=0.
- Reset asserted after 2 of 4 beats accepted -> outputs return to reset values, no write that cycle. Reload of 1 beat with in_last -> writes addr 0, done=1.
- in_valid toggling randomly with held fields -> exactly one write per handshake, addresses contiguous, no duplicate writes.
